icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped, read-only instruction cache between the core's ROM port
//  (rom_ce_o/rom_addr_o/rom_data_i) and a slow word-wide instruction memory
//  with req/ack handshake. Hits return data combinationally with zero added
//  latency. Misses raise stallreq_o while the line refills word by word.
// PARAMETERS
//  INDEX_W     6   index bits; number of lines = 2**INDEX_W
//  LINE_WORDS  4   32-bit words per line; power of 2, >=2; OFFSET_W=log2(LINE_WORDS)
// PORTS
//  clk           in   1   single clock; all state updates on rising edge
//  rst           in   1   synchronous, active-high reset
//  rom_ce_i      in   1   core fetch enable
//  rom_addr_i    in   32  fetch byte address; bits [1:0] ignored
//  rom_data_o    out  32  instruction word; valid when ce=1 and stallreq_o=0
//  stallreq_o    out  1   core holds PC/IF while high
//  inval_i       in   1   one-cycle pulse: invalidate all lines
//  mem_req_o     out  1   refill request; held until mem_ack_i
//  mem_addr_o    out  32  word-aligned refill address; stable while req=1
//  mem_ack_i     in   1   mem_rdata_i valid this cycle; ignored when req=0
//  mem_rdata_i   in   32  refill data
// BEHAVIOUR
//  addr split: tag=[31:2+OFFSET_W+INDEX_W], index, offset=[2+OFFSET_W-1:2].
//  Reset: all valid bits 0, state IDLE, mem_req_o=0, mem_addr_o=0, counter=0;
//   stallreq_o=0, rom_data_o=0 while rom_ce_i=0.
//  rom_ce_i=0: rom_data_o=0, stallreq_o=0, no lookup, no refill started.
//  IDLE, hit (valid & tag match): rom_data_o=data[index][offset], stall=0.
//  IDLE, miss: stallreq_o=1 combinationally, rom_data_o=0; next edge ->
//   REFILL, latch tag/index, line base addr, word counter=0, clear valid[index].
//  REFILL: mem_req_o=1, mem_addr_o=base+4*cnt; stallreq_o=1 every cycle.
//   On ack: write mem_rdata_i to data[idx][cnt], cnt++; req stays high with
//   next address (back-to-back acks allowed). On last ack: write tag, set
//   valid, -> IDLE; mem_req_o=0 next cycle; following cycle hits.
//  Miss penalty with 0-wait memory: stall for 1+LINE_WORDS cycles.
//  rom_addr_i changing during REFILL: refill completes for latched line; new
//   address looked up in IDLE afterward.
//  inval_i in IDLE: all valid cleared next edge; same-cycle lookup uses old
//   state. inval_i during REFILL: refill completes, line NOT validated.
//  inval_i concurrent with last ack: invalidate wins.
//  Line is aligned: burst never crosses 0xFFFF_FFFC -> 0 wrap.
//  rst mid-REFILL: abort, IDLE, mem_req_o=0 next cycle, all lines invalid.
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds outputs hit_cnt_o[31:0], miss_cnt_o[31:0];
//   hit_cnt++ each IDLE cycle with ce=1 and hit; miss_cnt++ on each
//   IDLE->REFILL; both wrap modulo 2**32, cleared by rst, not by inval_i.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  defines.v: `ICacheStateBus, `ICacheIdle, `ICacheRefill encodings,
//   `ICacheTagBus width derived from INDEX_W/LINE_WORDS defaults.
//  One sub-module icache_tag_array: valid+tag storage, combinational lookup,
//   single write port, synchronous clear-all. Data array and FSM in top.
// TESTING
//  1 rst, ce=1 addr 0x0000_0000, mem ack same cycle, words 0x11,0x22,0x33,0x44
//    -> stall 5 cycles, mem_addr 0x0,0x4,0x8,0xC, then rom_data_o=0x11.
//  2 after T1, addr 0x8 -> rom_data_o=0x33, stallreq_o=0 same cycle, no req.
//  3 addr 0x400 (same index, new tag, INDEX_W=6) -> miss, refill 0x400..0x40C;
//    back to 0x0 -> miss again (conflict eviction).
//  4 ack delayed 3 cycles per word -> mem_addr stable while waiting,
//    stall = 1+4*4 cycles; ack pulses with req=0 ignored.
//  5 inval_i during refill of 0x100 -> refill completes, next fetch of
//    0x100 misses; inval_i in IDLE -> 0x0 misses next lookup.
//  6 rst asserted mid-refill -> mem_req_o=0 next cycle, prior lines miss;
//    with ICACHE_STATS_EN, T1+T2 yield miss_cnt_o=1, hit_cnt_o=2.

Source files
------------

// File: rtl/icache_dm_pkg.sv
// Shared types and defaults for the direct-mapped instruction cache.
// Optional statistics counters are enabled by defining ICACHE_STATS_EN.
package icache_dm_pkg;

  typedef enum logic [0:0] {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

  localparam int ICACHE_INDEX_W    = 6;
  localparam int ICACHE_LINE_WORDS = 4;

  // Tag width left over from a 30-bit word address after index and offset.
  function automatic int icache_tag_w(input int index_w, input int line_words);
    return 30 - index_w - $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tags for every line: combinational lookup, one write port,
// synchronous clear-all that takes priority over the write port.
module icache_tag_array #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_all,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_reg;
  logic [TAG_W-1:0] tag_mem [LINES];

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst || clear_all) begin
          valid_reg[gi] <= 1'b0;
        end else if (we && (wr_index == INDEX_W'(gi))) begin
          valid_reg[gi] <= wr_valid;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  assign hit = valid_reg[rd_index] && (tag_mem[rd_index] == rd_tag);

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with zero-latency hits and
// word-by-word refill over a req/ack port. ICACHE_STATS_EN adds hit/miss counters.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int INDEX_W    = ICACHE_INDEX_W,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        stallreq_o,
  input  logic        inval_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int TAG_W    = icache_tag_w(INDEX_W, LINE_WORDS);
  localparam int LINE_W   = TAG_W + INDEX_W;
  localparam int DEPTH    = LINE_WORDS << INDEX_W;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic                unused_addr_bits;

  assign req_tag          = rom_addr_i[31 -: TAG_W];
  assign req_index        = rom_addr_i[2+OFFSET_W +: INDEX_W];
  assign req_offset       = rom_addr_i[2 +: OFFSET_W];
  assign unused_addr_bits = ^rom_addr_i[1:0];

  icache_state_e       state_reg, state_next;
  logic [LINE_W-1:0]   line_reg, line_next;
  logic [OFFSET_W-1:0] cnt_reg, cnt_next;
  logic                inval_seen_reg, inval_seen_next;

  logic [31:0] data_mem [DEPTH];

  logic               hit;
  logic               tag_we;
  logic [INDEX_W-1:0] tag_wr_index;
  logic [TAG_W-1:0]   tag_wr_tag;
  logic               tag_wr_valid;
  logic               data_we;
  logic [TAG_W-1:0]   refill_tag;
  logic [INDEX_W-1:0] refill_index;
  logic               last_word;

  assign refill_tag   = line_reg[LINE_W-1 -: TAG_W];
  assign refill_index = line_reg[INDEX_W-1:0];
  assign last_word    = (cnt_reg == OFFSET_W'(LINE_WORDS - 1));
  // Line base is aligned, so base + 4*cnt never carries out of the line.
  assign mem_addr_o   = {line_reg, cnt_reg, 2'b00};

  icache_tag_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tags (
    .clk       (clk),
    .rst       (rst),
    .clear_all (inval_i),
    .rd_index  (req_index),
    .rd_tag    (req_tag),
    .hit       (hit),
    .we        (tag_we),
    .wr_index  (tag_wr_index),
    .wr_tag    (tag_wr_tag),
    .wr_valid  (tag_wr_valid)
  );

  always_comb begin
    state_next      = state_reg;
    line_next       = line_reg;
    cnt_next        = cnt_reg;
    inval_seen_next = inval_seen_reg;
    stallreq_o      = 1'b0;
    rom_data_o      = '0;
    mem_req_o       = 1'b0;
    tag_we          = 1'b0;
    tag_wr_index    = refill_index;
    tag_wr_tag      = refill_tag;
    tag_wr_valid    = 1'b0;
    data_we         = 1'b0;
    case (state_reg)
      ICACHE_IDLE: begin
        if (rom_ce_i) begin
          if (hit) begin
            rom_data_o = data_mem[{req_index, req_offset}];
          end else begin
            // Drop the victim's valid bit now so a partial line is never seen as a hit.
            stallreq_o      = 1'b1;
            state_next      = ICACHE_REFILL;
            line_next       = {req_tag, req_index};
            cnt_next        = '0;
            inval_seen_next = 1'b0;
            tag_we          = 1'b1;
            tag_wr_index    = req_index;
            tag_wr_tag      = req_tag;
          end
        end
      end
      ICACHE_REFILL: begin
        stallreq_o      = 1'b1;
        mem_req_o       = 1'b1;
        inval_seen_next = inval_seen_reg || inval_i;
        if (mem_ack_i) begin
          data_we  = 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (last_word) begin
            tag_we       = 1'b1;
            tag_wr_valid = !(inval_seen_reg || inval_i);
            state_next   = ICACHE_IDLE;
          end
        end
      end
      default: state_next = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ICACHE_IDLE;
      line_reg       <= '0;
      cnt_reg        <= '0;
      inval_seen_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      line_reg       <= line_next;
      cnt_reg        <= cnt_next;
      inval_seen_reg <= inval_seen_next;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[{refill_index, cnt_reg}] <= mem_rdata_i;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if ((state_reg == ICACHE_IDLE) && rom_ce_i) begin
      if (hit) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      else     miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_reg;
  assign miss_cnt_o = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Randomised and directed bench for icache_dm against a line-level cache model
// and a behavioural memory responder with programmable ack delay.
module tb_icache_dm;

  localparam int LW    = 4;
  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        inval_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  icache_dm dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_i    (rom_ce_i),
    .rom_addr_i  (rom_addr_i),
    .rom_data_o  (rom_data_o),
    .stallreq_o  (stallreq_o),
    .inval_i     (inval_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-line valid + tag; data always equals backing memory.
  bit          mvalid [LINES];
  logic [31:0] mtag   [LINES];

  // Memory responder state
  int          ack_delay = 0;
  bit          spurious = 1'b0;
  int          wait_cnt = 0;
  bit          waited = 1'b0;
  logic [31:0] wait_addr = '0;
  bit          addr_unstable = 1'b0;
  logic [31:0] acked [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd16) return 32'h11 * ((a >> 2) + 32'd1);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mem_req_o) begin
      if (waited && (mem_addr_o !== wait_addr)) addr_unstable = 1'b1;
      if (wait_cnt >= ack_delay) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_word(mem_addr_o);
        acked.push_back(mem_addr_o);
        wait_cnt = 0;
        waited   = 1'b0;
      end else begin
        mem_ack_i = 1'b0;
        wait_cnt++;
        waited    = 1'b1;
        wait_addr = mem_addr_o;
      end
    end else begin
      wait_cnt    = 0;
      waited      = 1'b0;
      mem_ack_i   = spurious;
      mem_rdata_i = spurious ? 32'hDEAD_BEEF : 32'h0;
    end
  end

  // One fetch held until the cache stops stalling; inval_at>0 pulses inval in that stall cycle.
  task automatic fetch(input logic [31:0] addr, input int delay, input int inval_at, input string tag);
    int n, idx, rounds, exp_stall;
    logic [31:0] t, base;
    bit exp_hit;
    idx  = int'((addr >> 4) % LINES);
    t    = addr >> 10;
    base = addr & 32'hFFFF_FFF0;
    exp_hit   = mvalid[idx] && (mtag[idx] == t);
    rounds    = exp_hit ? 0 : ((inval_at > 0) ? 2 : 1);
    exp_stall = rounds * (1 + LW * (1 + delay));
    @(posedge clk); #1;
    ack_delay = delay;
    acked.delete();
    rom_ce_i = 1'b1;
    rom_addr_i = addr;
    inval_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (stallreq_o && n < 200) begin
      if (n == 0) chk({tag, "_miss_data"}, rom_data_o, 32'h0);
      n++;
      @(posedge clk); #1;
      inval_i = (n == inval_at);
      @(negedge clk);
    end
    chk({tag, "_stall"}, n, exp_stall);
    chk({tag, "_data"}, rom_data_o, mem_word(addr & 32'hFFFF_FFFC));
    chk({tag, "_req_idle"}, {31'b0, mem_req_o}, 32'h0);
    if (rounds > 0) begin
      chk({tag, "_nacks"}, acked.size(), LW * rounds);
      for (int i = 0; i < acked.size(); i++)
        chk({tag, "_addr"}, acked[i], base + 32'(4 * (i % LW)));
      if (rounds == 2) model_clear();
      mvalid[idx] = 1'b1;
      mtag[idx]   = t;
    end
    $display("fetch %-8s addr=%h stall=%0d data=%h", tag, addr, n, rom_data_o);
    @(posedge clk); #1;
    rom_ce_i = 1'b0;
    inval_i  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rom_ce_i = 1'b0;
    rom_addr_i = '0;
    inval_i = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'b0, stallreq_o}, 32'h0);
    chk("rst_data", rom_data_o, 32'h0);
    chk("rst_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_maddr", mem_addr_o, 32'h0);
    $display("reset  stall=%0d req=%0d", stallreq_o, mem_req_o);

    fetch(32'h0000_0000, 0, -1, "t1");
    fetch(32'h0000_0008, 0, -1, "t2");
    fetch(32'h0000_0400, 0, -1, "t3_new");
    fetch(32'h0000_0000, 0, -1, "t3_back");

    addr_unstable = 1'b0;
    fetch(32'h0000_0044, 3, -1, "t4_slow");
    chk("t4_addr_stable", {31'b0, addr_unstable}, 32'h0);

    spurious = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("spur_req", {31'b0, mem_req_o}, 32'h0);
      chk("spur_stall", {31'b0, stallreq_o}, 32'h0);
    end
    @(posedge clk); #1 spurious = 1'b0;
    fetch(32'h0000_0048, 0, -1, "spur_hit");

    fetch(32'h0000_0100, 1, 2, "t5_inv");
    @(posedge clk); #1;
    rom_ce_i = 1'b1;
    rom_addr_i = 32'h0000_0104;
    inval_i = 1'b1;
    @(negedge clk);
    chk("inv_same_stall", {31'b0, stallreq_o}, 32'h0);
    chk("inv_same_data", rom_data_o, mem_word(32'h0000_0104));
    $display("inval  same-cycle stall=%0d data=%h", stallreq_o, rom_data_o);
    @(posedge clk); #1;
    inval_i = 1'b0;
    rom_ce_i = 1'b0;
    model_clear();
    fetch(32'h0000_0100, 0, -1, "t5_post");

    fetch(32'hFFFF_FFFC, 0, -1, "top");

    @(posedge clk); #1;
    ack_delay = 3;
    rom_ce_i = 1'b1;
    rom_addr_i = 32'h0000_2000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_req_before", {31'b0, mem_req_o}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    rom_ce_i = 1'b0;
    @(negedge clk);
    chk("t6_req_after", {31'b0, mem_req_o}, 32'h0);
    chk("t6_stall_after", {31'b0, stallreq_o}, 32'h0);
    $display("rst mid-refill req=%0d", mem_req_o);
    model_clear();
    fetch(32'h0000_0008, 0, -1, "t6_miss");

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 2)) << 12) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      fetch(a, int'($urandom_range(0, 2)), -1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
